// File: rtl/timer_irq_source.sv
// Memory-mapped down-counting timer that drives the CPU interrupt line.
// One-shot or auto-reload; a write to CTRL acknowledges the pending flag.
module timer_irq_source #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int unsigned WIDTH     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_e;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    state_e           state_q;
    logic             en_q;
    logic [1:0]       mode_q;
    logic             im_q;
    logic             irq_flag_q;
    logic [WIDTH-1:0] preset_q;
    logic [WIDTH-1:0] count_q;

    logic       hit;
    logic [1:0] offset;
    logic       wr_ctrl;
    logic       wr_preset;
    logic       auto_reload;
    logic       unused_addr_bits;

    assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset      = addr[3:2];
    assign wr_ctrl     = we && hit && (offset == OFF_CTRL);
    assign wr_preset   = we && hit && (offset == OFF_PRESET);
    // MODE 2'b1x falls back to one-shot.
    assign auto_reload = (mode_q == 2'b01);
    assign unused_addr_bits = ^addr[1:0];

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (offset)
                OFF_CTRL:   rdata[4:0]       = {irq_flag_q, im_q, mode_q, en_q};
                OFF_PRESET: rdata[WIDTH-1:0] = preset_q;
                OFF_COUNT:  rdata[WIDTH-1:0] = count_q;
                default:    rdata            = '0;
            endcase
        end
    end

    assign irq = im_q & irq_flag_q;

    // NOTE: the FSM branches on pre-edge CTRL; the CTRL write block sits after
    // the case so its non-blocking assignments win over the FSM clearing EN,
    // while the flag clear sits before the case so an FSM set wins over it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            mode_q     <= 2'b00;
            im_q       <= 1'b0;
            irq_flag_q <= 1'b0;
            preset_q   <= '0;
            count_q    <= '0;
        end else begin
            if (wr_preset) begin
                preset_q <= wdata[WIDTH-1:0];
            end
            if (wr_ctrl) begin
                irq_flag_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (en_q) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    count_q <= preset_q;
                    state_q <= CNT;
                end
                CNT: begin
                    if (!en_q) begin
                        state_q <= IDLE;
                    end else if (count_q != '0) begin
                        count_q <= count_q - WIDTH'(1);
                    end else begin
                        irq_flag_q <= 1'b1;
                        state_q    <= INT;
                    end
                end
                INT: begin
                    if (auto_reload) begin
                        irq_flag_q <= 1'b0;
                        state_q    <= LOAD;
                    end else begin
                        en_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (wr_ctrl) begin
                en_q   <= wdata[0];
                mode_q <= wdata[2:1];
                im_q   <= wdata[3];
            end
        end
    end

endmodule

// File: tb/tb_timer_irq_source.sv
// Directed bench for timer_irq_source: register access, one-shot, auto-reload,
// disable, masking, same-edge collisions and asynchronous reset.
module tb_timer_irq_source;

    localparam logic [31:0] CTRL_A   = 32'h0000_7F00;
    localparam logic [31:0] PRESET_A = 32'h0000_7F04;
    localparam logic [31:0] COUNT_A  = 32'h0000_7F08;
    localparam logic [31:0] RSV_A    = 32'h0000_7F0C;
    localparam logic [31:0] OTHER_A  = 32'h0000_7E04;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int fails  = 0;

    timer_irq_source dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        we   = 1'b0;
        #1;
        d = rdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        peek(CTRL_A, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_ctrl: got %h expected %h", d, 32'h0); end
        peek(PRESET_A, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_preset: got %h expected %h", d, 32'h0); end
        peek(COUNT_A, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_count: got %h expected %h", d, 32'h0); end
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irq); end
        bus_write(PRESET_A, 32'h1234);
        peek(PRESET_A, d);
        checks++; if (d !== 32'h1234) begin fails++; $display("FAIL preset_rw: got %h expected %h", d, 32'h1234); end
        bus_write(COUNT_A, 32'h5);
        peek(COUNT_A, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL count_ro: got %h expected %h", d, 32'h0); end
        bus_write(RSV_A, 32'hFFFF_FFFF);
        peek(RSV_A, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL reserved_rd: got %h expected %h", d, 32'h0); end
        peek(OTHER_A, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL undecoded_rd: got %h expected %h", d, 32'h0); end
    endtask

    task automatic test_one_shot();
        logic [31:0] d;
        do_reset();
        bus_write(PRESET_A, 32'd3);
        bus_write(CTRL_A, 32'h9);
        tick();
        for (int k = 2; k <= 5; k++) begin
            tick();
            peek(COUNT_A, d);
            checks++; if (d !== 32'(5 - k)) begin fails++; $display("FAIL oneshot_count_e%0d: got %h expected %h", k, d, 32'(5 - k)); end
            checks++; if (irq !== 1'b0) begin fails++; $display("FAIL oneshot_irq_early_e%0d: got %b expected 0", k, irq); end
        end
        tick();
        checks++; if (irq !== 1'b1) begin fails++; $display("FAIL oneshot_irq_rise: got %b expected 1", irq); end
        tick();
        peek(CTRL_A, d);
        checks++; if (d !== 32'h18) begin fails++; $display("FAIL oneshot_ctrl_done: got %h expected %h", d, 32'h18); end
        repeat (3) tick();
        checks++; if (irq !== 1'b1) begin fails++; $display("FAIL oneshot_irq_held: got %b expected 1", irq); end
        bus_write(CTRL_A, 32'h8);
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL oneshot_ack_irq: got %b expected 0", irq); end
        peek(CTRL_A, d);
        checks++; if (d !== 32'h8) begin fails++; $display("FAIL oneshot_ack_ctrl: got %h expected %h", d, 32'h8); end
    endtask

    task automatic test_auto_reload();
        logic [31:0] d;
        logic        exp_irq;
        do_reset();
        bus_write(PRESET_A, 32'd2);
        bus_write(CTRL_A, 32'hB);
        for (int k = 1; k <= 21; k++) begin
            tick();
            exp_irq = (k % 5 == 0);
            checks++; if (irq !== exp_irq) begin fails++; $display("FAIL auto_irq_e%0d: got %b expected %b", k, irq, exp_irq); end
            peek(CTRL_A, d);
            checks++; if (d[0] !== 1'b1) begin fails++; $display("FAIL auto_en_e%0d: got %b expected 1", k, d[0]); end
        end
    endtask

    task automatic test_disable();
        logic [31:0] d;
        logic        found;
        do_reset();
        bus_write(PRESET_A, 32'd10);
        bus_write(CTRL_A, 32'h9);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            checks++; if (irq !== 1'b0) begin fails++; $display("FAIL disable_irq_run: got %b expected 0", irq); end
            peek(COUNT_A, d);
            if (d == 32'd6) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin fails++; $display("FAIL disable_reach6: got %b expected 1 within 20 cycles", found); end
        bus_write(CTRL_A, 32'h8);
        repeat (3) tick();
        peek(COUNT_A, d);
        checks++; if (d !== 32'd5) begin fails++; $display("FAIL disable_frozen: got %h expected %h", d, 32'd5); end
        peek(CTRL_A, d);
        checks++; if (d !== 32'h8) begin fails++; $display("FAIL disable_ctrl: got %h expected %h", d, 32'h8); end
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL disable_irq: got %b expected 0", irq); end
        bus_write(CTRL_A, 32'h9);
        tick();
        peek(COUNT_A, d);
        checks++; if (d !== 32'd5) begin fails++; $display("FAIL reenable_load_cycle: got %h expected %h", d, 32'd5); end
        tick();
        peek(COUNT_A, d);
        checks++; if (d !== 32'd10) begin fails++; $display("FAIL reenable_reload: got %h expected %h", d, 32'd10); end
    endtask

    task automatic test_mask();
        logic [31:0] d;
        do_reset();
        bus_write(PRESET_A, 32'd1);
        bus_write(CTRL_A, 32'h1);
        repeat (5) tick();
        peek(CTRL_A, d);
        checks++; if (d !== 32'h10) begin fails++; $display("FAIL mask_pend: got %h expected %h", d, 32'h10); end
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL mask_irq: got %b expected 0", irq); end
        bus_write(CTRL_A, 32'h8);
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL mask_unmask_irq: got %b expected 0", irq); end
        peek(CTRL_A, d);
        checks++; if (d !== 32'h8) begin fails++; $display("FAIL mask_unmask_ctrl: got %h expected %h", d, 32'h8); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        do_reset();
        bus_write(CTRL_A, 32'h9);
        tick();
        tick();
        peek(COUNT_A, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL zero_count: got %h expected %h", d, 32'h0); end
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL zero_irq_early: got %b expected 0", irq); end
        bus_write(CTRL_A, 32'h9);
        peek(CTRL_A, d);
        checks++; if (d !== 32'h19) begin fails++; $display("FAIL set_beats_ack: got %h expected %h", d, 32'h19); end
        checks++; if (irq !== 1'b1) begin fails++; $display("FAIL set_beats_ack_irq: got %b expected 1", irq); end
        bus_write(CTRL_A, 32'h9);
        peek(CTRL_A, d);
        checks++; if (d !== 32'h9) begin fails++; $display("FAIL write_beats_en_clear: got %h expected %h", d, 32'h9); end
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL write_beats_irq: got %b expected 0", irq); end
        tick();
        tick();
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL restart_irq_early: got %b expected 0", irq); end
        tick();
        checks++; if (irq !== 1'b1) begin fails++; $display("FAIL restart_irq: got %b expected 1", irq); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        logic        seen;
        do_reset();
        bus_write(PRESET_A, 32'd2);
        bus_write(CTRL_A, 32'hB);
        repeat (7) tick();
        #1;
        reset = 1'b0;
        peek(CTRL_A, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL async_ctrl: got %h expected %h", d, 32'h0); end
        checks++; if (irq !== 1'b0) begin fails++; $display("FAIL async_irq: got %b expected 0", irq); end
        peek(PRESET_A, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL async_preset: got %h expected %h", d, 32'h0); end
        peek(COUNT_A, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL async_count: got %h expected %h", d, 32'h0); end
        #2;
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (irq !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL async_no_irq: got %b expected 0", seen); end
        peek(CTRL_A, d);
        checks++; if (d !== 32'h0) begin fails++; $display("FAIL async_ctrl_after: got %h expected %h", d, 32'h0); end
    endtask

    initial begin
        reset = 1'b0;
        addr  = 32'h0;
        we    = 1'b0;
        wdata = 32'h0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_disable();
        test_mask();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
